// File: rtl/spatten_run_ctrl.sv
// spatten_run_ctrl: host run controller that starts the accelerator, waits for completion,
// captures baseline/pipelined cycle counts and reports the improvement in hundredths of a
// percent. Optional WAIT-state abort is enabled by defining SPATTEN_RUN_TIMEOUT_EN.
module spatten_run_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic        busy,
    output logic        acc_start,
    input  logic        acc_done,
    input  logic [63:0] base_cycles_in,
    input  logic [63:0] pipe_cycles_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_base,
    output logic [63:0] res_pipe,
    output logic [31:0] res_impr,
    output logic        res_timeout
);
    typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, DIVIDE, REPORT} state_t;

    state_t      state_q, state_d;
    logic [63:0] base_q, base_d, pipe_q, pipe_d, rem_q, rem_d, diff;
    logic [31:0] impr_q, impr_d;
    logic [79:0] quo_q, quo_d;
    logic [6:0]  dcnt_q, dcnt_d;
    logic [64:0] trial;
    logic        ge;
`ifdef SPATTEN_RUN_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        to_q, to_d;
`endif

    if (TIMEOUT_CYCLES < 32'd1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Next-state and datapath: quo_q holds the numerator and shifts in quotient bits during DIVIDE
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        pipe_d  = pipe_q;
        impr_d  = impr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dcnt_d  = dcnt_q;
`ifdef SPATTEN_RUN_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = to_q;
`endif
        diff    = base_cycles_in > pipe_cycles_in ? base_cycles_in - pipe_cycles_in : 64'd0;
        trial   = {rem_q, quo_q[79]};
        ge      = trial >= {1'b0, base_q};
        case (state_q)
            IDLE: state_d = go ? START : IDLE;
            START: begin
                state_d = WAIT;
`ifdef SPATTEN_RUN_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (acc_done) begin
                    state_d = CAPTURE;
`ifdef SPATTEN_RUN_TIMEOUT_EN
                end else if (cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                    state_d = REPORT;
                    to_d    = 1'b1;
                    base_d  = '0;
                    pipe_d  = '0;
                    impr_d  = '0;
                end else begin
                    cnt_d   = cnt_q + 32'd1;
`endif
                end
            end
            CAPTURE: begin
                base_d  = base_cycles_in;
                pipe_d  = pipe_cycles_in;
                impr_d  = '0;
                rem_d   = '0;
                quo_d   = {16'd0, diff} * 80'd10000;
                dcnt_d  = '0;
                state_d = base_cycles_in == 64'd0 ? REPORT : DIVIDE;
`ifdef SPATTEN_RUN_TIMEOUT_EN
                to_d    = 1'b0;
`endif
            end
            DIVIDE: begin
                rem_d   = ge ? 64'(trial - {1'b0, base_q}) : trial[63:0];
                quo_d   = {quo_q[78:0], ge};
                dcnt_d  = dcnt_q + 7'd1;
                if (dcnt_q == 7'd79) begin
                    state_d = REPORT;
                    impr_d  = {quo_q[30:0], ge};
                end
            end
            REPORT: state_d = res_ready ? IDLE : REPORT;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any run in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            pipe_q  <= '0;
            impr_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dcnt_q  <= '0;
`ifdef SPATTEN_RUN_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            pipe_q  <= pipe_d;
            impr_q  <= impr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dcnt_q  <= dcnt_d;
`ifdef SPATTEN_RUN_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign busy      = state_q != IDLE;
    assign acc_start = state_q == START;
    assign res_valid = state_q == REPORT;
    assign res_base  = base_q;
    assign res_pipe  = pipe_q;
    assign res_impr  = impr_q;
`ifdef SPATTEN_RUN_TIMEOUT_EN
    assign res_timeout = to_q;
`else
    assign res_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_spatten_run_ctrl.sv
// tb_spatten_run_ctrl: scoreboard bench for spatten_run_ctrl (SPATTEN_RUN_TIMEOUT_EN selects timeout case)
module tb_spatten_run_ctrl;
    localparam logic [31:0] TO = 32'd2000;

    logic        clk = 1'b0, rst = 1'b1, go = 1'b0, acc_done = 1'b0, res_ready = 1'b1;
    logic [63:0] base_cycles_in = '0, pipe_cycles_in = '0;
    logic        busy, acc_start, res_valid, res_timeout;
    logic [63:0] res_base, res_pipe;
    logic [31:0] res_impr;

    typedef struct {
        logic [63:0] b;
        logic [63:0] p;
        logic [31:0] i;
        logic        t;
        int          due;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    int   total = 0, bad = 0, cyc = 0, starts = 0;
    logic vprev = 1'b0;

    spatten_run_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .acc_start(acc_start),
        .acc_done(acc_done), .base_cycles_in(base_cycles_in), .pipe_cycles_in(pipe_cycles_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_base(res_base), .res_pipe(res_pipe),
        .res_impr(res_impr), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (acc_start) starts++;
        if (rst) vprev = 1'b0;
        else begin
            if (res_valid && !vprev) begin
                if (q.size() == 0) chk("sb_unexpected_result", 64'd1, 64'd0);
                else begin
                    cur = q.pop_front();
                    chk("latency", 64'(cyc), 64'(cur.due));
                end
            end
            if (res_valid) begin
                chk("res_base", res_base, cur.b);
                chk("res_pipe", res_pipe, cur.p);
                chk("res_impr", 64'(res_impr), 64'(cur.i));
                chk("res_timeout", 64'(res_timeout), 64'(cur.t));
            end
            vprev = res_valid;
        end
    end

    task automatic run(input logic [63:0] b, input logic [63:0] p, input int dly,
                       input logic [31:0] impr, input int lat, input int hold, input bit push);
        int n0, hv;
        n0 = starts;
        hv = 0;
        base_cycles_in = b;
        pipe_cycles_in = p;
        res_ready = (hold == 0);
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        chk("start_pulse", 64'(acc_start), 64'd1);
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1 go = 1'b1;
        end
        go = 1'b0;
        chk("busy_in_wait", 64'(busy), 64'd1);
        acc_done = 1'b1;
        if (push) q.push_back('{b, p, impr, 1'b0, cyc + lat});
        @(posedge clk); #1 acc_done = 1'b0;
        if (push) begin
            for (int i = 0; i < 300 && busy; i++) begin
                @(posedge clk); #1;
                if (res_valid) begin
                    hv++;
                    if (hv > hold) res_ready = 1'b1;
                end
            end
            chk("run_idle", 64'(busy), 64'd0);
            chk("one_start", 64'(starts - n0), 64'd1);
            chk("hold_impr", 64'(res_impr), 64'(impr));
        end
        res_ready = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start", 64'(acc_start), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_impr", 64'(res_impr), 64'd0);
        rst = 1'b0;
        run(64'd1000, 64'd750, 10, 32'd2500, 82, 0, 1'b1);
        run(64'd500, 64'd600, 5, 32'd0, 82, 0, 1'b1);
        run(64'd0, 64'd0, 3, 32'd0, 2, 0, 1'b1);
        run(64'd2000, 64'd1000, 4, 32'd5000, 82, 5, 1'b1);
        run(64'd7, 64'd0, 1, 32'd10000, 82, 0, 1'b1);
        run(64'd3, 64'd1, 2, 32'd6666, 82, 0, 1'b1);
        run(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6, 32'd9999, 82, 0, 1'b1);
`ifdef SPATTEN_RUN_TIMEOUT_EN
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        chk("to_start_pulse", 64'(acc_start), 64'd1);
        q.push_back('{64'd0, 64'd0, 32'd0, 1'b1, cyc + 1 + int'(TO)});
        for (int i = 0; i < int'(TO) + 50 && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("to_idle", 64'(busy), 64'd0);
        chk("to_flag_held", 64'(res_timeout), 64'd1);
        run(64'd10, 64'd5, 3, 32'd5000, 82, 0, 1'b1);
`else
        run(64'd100, 64'd40, 5000, 32'd6000, 82, 0, 1'b1);
`endif
        run(64'd1000, 64'd750, 2, 32'd2500, 82, 0, 1'b0);
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_start", 64'(acc_start), 64'd0);
        chk("arst_valid", 64'(res_valid), 64'd0);
        chk("arst_timeout", 64'(res_timeout), 64'd0);
        chk("arst_base", res_base, 64'd0);
        chk("arst_pipe", res_pipe, 64'd0);
        chk("arst_impr", 64'(res_impr), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("no_run_without_go", 64'(busy), 64'd0);
        run(64'd3, 64'd2, 4, 32'd3333, 82, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spatten_run_ctrl.md
SPATTEN_RUN_CTRL -- requirements
Module: spatten_run_ctrl

Interface
REQ-001 SHALL provide parameter: TIMEOUT_CYCLES, 2000, maximum WAIT-state cycles before run abort (32-bit, >=1).
REQ-002 SHALL provide port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port: go  input  1  host run request, sampled only in IDLE.
REQ-005 SHALL provide port: busy  output  1  high in every state except IDLE.
REQ-006 SHALL provide port: acc_start  output  1  one-cycle start pulse to accelerator.
REQ-007 SHALL provide port: acc_done  input  1  accelerator completion level.
REQ-008 SHALL provide port: base_cycles_in  input  64  accelerator baseline total cycles.
REQ-009 SHALL provide port: pipe_cycles_in  input  64  accelerator pipelined total cycles.
REQ-010 SHALL provide port: res_valid  output  1  result record valid.
REQ-011 SHALL provide port: res_ready  input  1  host accepts result record.
REQ-012 SHALL provide port: res_base / res_pipe  output  64 each  captured cycle counts.
REQ-013 SHALL provide port: res_impr  output  32  improvement in hundredths of a percent.
REQ-014 SHALL provide port: res_timeout  output  1  run aborted by timeout.

Function
REQ-015 SHALL implement FSM states IDLE, START, WAIT, CAPTURE, DIVIDE, REPORT.
REQ-016 IDLE: go=1 at edge N -> START; acc_start high for exactly the cycle after edge N; go ignored in all other states.
REQ-017 START -> WAIT unconditionally after one cycle; timeout counter cleared on entry to WAIT.
REQ-018 WAIT: acc_done=1 -> CAPTURE, including on the first WAIT cycle; acc_done ignored outside WAIT.
REQ-019 CAPTURE (one cycle): register base_cycles_in and pipe_cycles_in; diff = base-pipe if base>pipe, else 0; numerator = diff*10000 held at 80 bits, no truncation.
REQ-020 CAPTURE: base=0 -> res_impr=0, go directly to REPORT; otherwise -> DIVIDE.
REQ-021 DIVIDE: restoring unsigned division numerator/base, one quotient bit per cycle, exactly 80 cycles, then REPORT.
REQ-022 Quotient SHALL be <=10000 by construction; res_impr = quotient low 32 bits, truncating (floor) division.
REQ-023 REPORT: res_valid high and all res_* stable until the cycle with res_ready=1; that edge -> IDLE, res_valid low next cycle.
REQ-024 res_ready already high on REPORT entry SHALL complete handshake in one cycle.
REQ-025 res_* SHALL hold last reported values while in IDLE until next CAPTURE or timeout overwrites them.
REQ-026 Latency acc_done sample -> res_valid: 82 cycles (base!=0), 2 cycles (base=0).

Reset
REQ-027 rst asserted SHALL immediately force IDLE; busy, acc_start, res_valid, res_timeout = 0; res_base, res_pipe, res_impr = 0; counters and divider cleared.
REQ-028 rst mid-run (any state) SHALL abandon the run with no result reported; rst release SHALL need a new go.

Configuration
REQ-029 Macro SPATTEN_RUN_TIMEOUT_EN defined: WAIT counts cycles; count reaching TIMEOUT_CYCLES without acc_done -> REPORT with res_timeout=1, res_base=res_pipe=res_impr=0.
REQ-030 Macro SPATTEN_RUN_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; res_timeout tied 0; TIMEOUT_CYCLES unused.
REQ-031 res_timeout SHALL be cleared to 0 on every CAPTURE.

Verification
REQ-032 base=1000, pipe=750, done 10 cycles after start -> res_impr=2500, res_timeout=0, res_valid 82 cycles after done.
REQ-033 base=500, pipe=600 -> res_impr=0, res_base=500, res_pipe=600.
REQ-034 base=0, pipe=0 -> res_impr=0, res_valid 2 cycles after done sample.
REQ-035 Macro defined, acc_done held 0 -> res_timeout=1 after 2000 WAIT cycles; macro undefined -> busy stays 1 for 5000 cycles.
REQ-036 res_ready low 5 cycles in REPORT -> res_valid and res_* constant; go pulses during run ignored; exactly one acc_start per run.
REQ-037 rst pulsed mid-DIVIDE -> all outputs 0 asynchronously, IDLE; next go runs normally with base=3, pipe=2 -> res_impr=3333.
